mor1kx_icache_refill_ctrl: RTL and testbench
============================================

# mor1kx_icache_refill_ctrl

Sequences instruction-cache line refills over the instruction bus. It sits between the instruction cache and the bus interface. When the cache raises a refill request, the block issues a critical-word-first wrapping burst for the missed line. Each returned word is forwarded to the cache write port (address, data, write enable). Bus errors abort the refill and are reported to the fetch stage.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32: data and address width.
- OPTION_ICACHE_BLOCK_WIDTH, 5: log2 of line size in bytes. Legal values: 4 (4 words) or 5 (8 words).

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- refill_req_i  in  1  cache requests a line refill.
- refill_adr_i  in  32  miss address; sampled when the request is accepted.
- ic_wradr_o  out  32  cache write address (word-aligned).
- ic_wrdat_o  out  32  cache write data.
- ic_we_o  out  1  cache write strobe; one per returned word.
- ibus_req_o  out  1  bus request.
- ibus_adr_o  out  32  bus address of the current beat.
- ibus_burst_o  out  1  high while more beats remain after the current one.
- ibus_ack_i  in  1  beat accepted; ibus_dat_i is valid.
- ibus_err_i  in  1  bus error on the current beat.
- ibus_dat_i  in  32  read data.
- busy_o  out  1  refill in progress.
- err_o  out  1  one-cycle pulse on an aborted refill.

## Operation
- States: IDLE, BURST, ERROR. One-hot encoded.
- IDLE: if refill_req_i, latch beat address = {refill_adr_i[31:2], 2'b00}, clear beat counter, go to BURST.
- BURST:
  - ibus_req_o=1; ibus_adr_o = current beat address.
  - ibus_burst_o = (beat counter != NBEATS-1), where NBEATS = 2^(OPTION_ICACHE_BLOCK_WIDTH-2).
  - On ibus_ack_i & !ibus_err_i:
    - ic_we_o=1, ic_wradr_o = beat address, ic_wrdat_o = ibus_dat_i.
    - Increment the counter.
    - Advance the address, wrapping inside the line: bits [BW-1:2] increment modulo NBEATS; bits [31:BW] unchanged.
  - After the NBEATS-th ack, go to IDLE.
- ibus_err_i in BURST:
  - No ic_we_o that cycle, even if ibus_ack_i is also high; error has priority.
  - ibus_req_o drops the next cycle; go to ERROR.
- ERROR: err_o=1 for exactly one cycle, then IDLE. The partially written line is not completed; the cache leaves it invalid.
- Requests are only accepted in IDLE. refill_req_i held high after completion starts a new refill, but never in the same cycle as the last ack.
- refill_adr_i is ignored outside IDLE.
- busy_o = state != IDLE.

## Timing
- Reset values: ic_we_o=0, ibus_req_o=0, ibus_burst_o=0, busy_o=0, err_o=0; addresses 0; state IDLE.
- ic_wradr_o, ic_wrdat_o and ic_we_o are combinational from ibus_ack_i and registered state: the cache write happens in the ack cycle.
- Request latency: refill_req_i sampled high at edge N → ibus_req_o high in cycle N+1.
- Minimum refill: 1 + NBEATS cycles from request to IDLE with zero-wait acks, plus one IDLE cycle before the next acceptance.
- ibus_adr_o and ibus_burst_o change only on the edge after an ack; they are stable while waiting.
- Reset mid-burst: the state returns to IDLE on the same edge. A late ibus_ack_i after reset produces no ic_we_o, because the strobe is gated by state == BURST.
- Wrap example, BW=5, miss at 0x1014: beats go 0x1014, 18, 1C, 00, 04, 08, 0C, 10.

## Structure
- State encodings (IDLE/BURST/ERROR) go in the shared defines file beside the other cache FSM encodings.
- No sub-module. The beat counter and wrap adder are inline, so the RTL is roughly 150 lines.

## Test plan
- BW=5, miss 0x2000_1014, zero-wait acks → 8 ic_we_o pulses:
  - addresses 0x…14, 18, 1C, 00, 04, 08, 0C, 10;
  - ibus_burst_o low only on the 0x…10 beat;
  - busy_o falls after the 8th ack.
- BW=4, miss 0x0000_0008, ack every 3rd cycle → addresses 08, 0C, 00, 04; each address held stable until its ack; exactly 4 writes.
- ibus_err_i with ibus_ack_i on beat 3 → no write on that beat; err_o pulses once 1 cycle later; ibus_req_o low; busy_o low 2 cycles after the error.
- rst asserted on beat 2 with ibus_ack_i still high the next cycle → outputs at reset values the next cycle; no further ic_we_o.
- refill_req_i held continuously with misses 0x100 then 0x200 → the second burst's ibus_req_o rises only after one IDLE cycle; the 0x200 address is latched at that acceptance.

Source files
------------

// File: rtl/mor1kx_icache_refill_ctrl_pkg.sv
// Shared encodings for the instruction-cache refill controller.
// States are one-hot so the output decode reduces to single-bit tests.
package mor1kx_icache_refill_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_BURST = 3'b010,
        ST_ERROR = 3'b100
    } refill_state_e;

    // Words per cache line for a given log2 line size in bytes.
    function automatic int nbeats(input int block_width);
        return 1 << (block_width - 2);
    endfunction

endpackage

// File: rtl/mor1kx_icache_refill_ctrl_if.sv
// Cache-side and instruction-bus-side signals of the refill controller.
// master = the controller itself, slave = the cache/bus environment around it.
interface mor1kx_icache_refill_ctrl_if #(
    parameter int AW = 32
) ();

    logic          refill_req_i;
    logic [AW-1:0] refill_adr_i;
    logic [AW-1:0] ic_wradr_o;
    logic [AW-1:0] ic_wrdat_o;
    logic          ic_we_o;
    logic          ibus_req_o;
    logic [AW-1:0] ibus_adr_o;
    logic          ibus_burst_o;
    logic          ibus_ack_i;
    logic          ibus_err_i;
    logic [AW-1:0] ibus_dat_i;
    logic          busy_o;
    logic          err_o;

    modport master (
        input  refill_req_i, refill_adr_i, ibus_ack_i, ibus_err_i, ibus_dat_i,
        output ic_wradr_o, ic_wrdat_o, ic_we_o, ibus_req_o, ibus_adr_o,
               ibus_burst_o, busy_o, err_o
    );

    modport slave (
        output refill_req_i, refill_adr_i, ibus_ack_i, ibus_err_i, ibus_dat_i,
        input  ic_wradr_o, ic_wrdat_o, ic_we_o, ibus_req_o, ibus_adr_o,
               ibus_burst_o, busy_o, err_o
    );

endinterface

// File: rtl/mor1kx_icache_refill_ctrl.sv
// Instruction-cache line refill: critical-word-first wrapping burst on the
// instruction bus, each returned word forwarded straight to the cache write port.
module mor1kx_icache_refill_ctrl
    import mor1kx_icache_refill_ctrl_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input logic                          clk,
    input logic                          rst,
    mor1kx_icache_refill_ctrl_if.master  bus
);

    localparam int W      = OPTION_OPERAND_WIDTH;
    localparam int BW     = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int CW     = BW - 2;
    localparam int NBEATS = nbeats(BW);

    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

    refill_state_e state_q, state_d;
    logic [W-1:0]  beat_adr_q, beat_adr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    // A beat is written to the cache only on a clean ack; an error wins over ack.
    logic beat_ok;
    assign beat_ok = (state_q == ST_BURST) && bus.ibus_ack_i && !bus.ibus_err_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_adr_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_adr_q <= beat_adr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default up front so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        beat_adr_d = beat_adr_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.refill_req_i) begin
                    state_d    = ST_BURST;
                    beat_adr_d = bus.refill_adr_i & ~W'(3);
                    beat_cnt_d = '0;
                end
            end

            ST_BURST: begin
                if (bus.ibus_err_i) begin
                    state_d = ST_ERROR;
                end else if (bus.ibus_ack_i) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    // Word index wraps inside the line; the line address is untouched.
                    beat_adr_d[BW-1:2] = beat_adr_q[BW-1:2] + CW'(1);
                    if (beat_cnt_q == LAST_BEAT)
                        state_d = ST_IDLE;
                end
            end

            ST_ERROR: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.ibus_req_o   = (state_q == ST_BURST);
        bus.ibus_adr_o   = beat_adr_q;
        bus.ibus_burst_o = (state_q == ST_BURST) && (beat_cnt_q != LAST_BEAT);
        bus.ic_we_o      = beat_ok;
        bus.ic_wradr_o   = beat_adr_q;
        bus.ic_wrdat_o   = bus.ibus_dat_i;
        bus.busy_o       = (state_q != ST_IDLE);
        bus.err_o        = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// Directed bench for the refill controller: an 8-word-line and a 4-word-line
// instance, driven step by step with hand-computed expectations.
module tb_mor1kx_icache_refill_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    mor1kx_icache_refill_ctrl_if #(.AW(32)) if5 ();
    mor1kx_icache_refill_ctrl_if #(.AW(32)) if4 ();

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH      (32),
        .OPTION_ICACHE_BLOCK_WIDTH (5)
    ) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (if5)
    );

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH      (32),
        .OPTION_ICACHE_BLOCK_WIDTH (4)
    ) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int off5 [8];
        int off4 [4];
        off5 = '{'h14, 'h18, 'h1C, 'h00, 'h04, 'h08, 'h0C, 'h10};
        off4 = '{'h08, 'h0C, 'h00, 'h04};

        if5.refill_req_i = 1'b0; if5.refill_adr_i = '0; if5.ibus_ack_i = 1'b0;
        if5.ibus_err_i   = 1'b0; if5.ibus_dat_i   = '0;
        if4.refill_req_i = 1'b0; if4.refill_adr_i = '0; if4.ibus_ack_i = 1'b0;
        if4.ibus_err_i   = 1'b0; if4.ibus_dat_i   = '0;

        // Reset values
        tick();
        tick();
        #1;
        check("rst_req",   {31'b0, if5.ibus_req_o},   32'd0);
        check("rst_burst", {31'b0, if5.ibus_burst_o}, 32'd0);
        check("rst_busy",  {31'b0, if5.busy_o},       32'd0);
        check("rst_err",   {31'b0, if5.err_o},        32'd0);
        check("rst_we",    {31'b0, if5.ic_we_o},      32'd0);
        check("rst_adr",   if5.ibus_adr_o,            32'd0);
        check("rst_wradr", if5.ic_wradr_o,            32'd0);
        check("rst_busy4", {31'b0, if4.busy_o},       32'd0);
        rst = 1'b0;
        tick();

        // BW=5, miss 0x2000_1014, zero-wait acks
        if5.refill_req_i = 1'b1;
        if5.refill_adr_i = 32'h2000_1014;
        #1;
        check("t1_idle_req", {31'b0, if5.ibus_req_o}, 32'd0);
        tick();
        if5.refill_req_i = 1'b0;
        if5.refill_adr_i = 32'hDEAD_BEEF;
        if5.ibus_ack_i   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if5.ibus_dat_i = 32'hC0DE_0000 + i;
            #1;
            check("t1_req",   {31'b0, if5.ibus_req_o},   32'd1);
            check("t1_busy",  {31'b0, if5.busy_o},       32'd1);
            check("t1_adr",   if5.ibus_adr_o,            32'h2000_1000 + off5[i]);
            check("t1_burst", {31'b0, if5.ibus_burst_o}, (i != 7) ? 32'd1 : 32'd0);
            check("t1_we",    {31'b0, if5.ic_we_o},      32'd1);
            check("t1_wradr", if5.ic_wradr_o,            32'h2000_1000 + off5[i]);
            check("t1_wrdat", if5.ic_wrdat_o,            32'hC0DE_0000 + i);
            tick();
        end
        if5.ibus_ack_i = 1'b0;
        #1;
        check("t1_end_busy", {31'b0, if5.busy_o},     32'd0);
        check("t1_end_req",  {31'b0, if5.ibus_req_o}, 32'd0);
        check("t1_end_we",   {31'b0, if5.ic_we_o},    32'd0);
        tick();

        // BW=4, miss 0x0000_0008, ack every third cycle
        if4.refill_req_i = 1'b1;
        if4.refill_adr_i = 32'h0000_0008;
        tick();
        if4.refill_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 2; w++) begin
                if4.ibus_ack_i = 1'b0;
                #1;
                check("t2_wait_adr",   if4.ibus_adr_o,            32'(off4[i]));
                check("t2_wait_burst", {31'b0, if4.ibus_burst_o}, (i != 3) ? 32'd1 : 32'd0);
                check("t2_wait_we",    {31'b0, if4.ic_we_o},      32'd0);
                check("t2_wait_req",   {31'b0, if4.ibus_req_o},   32'd1);
                tick();
            end
            if4.ibus_ack_i = 1'b1;
            if4.ibus_dat_i = 32'hA5A5_0000 + i;
            #1;
            check("t2_we",    {31'b0, if4.ic_we_o}, 32'd1);
            check("t2_wradr", if4.ic_wradr_o,       32'(off4[i]));
            check("t2_wrdat", if4.ic_wrdat_o,       32'hA5A5_0000 + i);
            tick();
        end
        if4.ibus_ack_i = 1'b0;
        #1;
        check("t2_end_busy", {31'b0, if4.busy_o},  32'd0);
        check("t2_end_we",   {31'b0, if4.ic_we_o}, 32'd0);
        tick();

        // BW=5, error together with ack on the third beat
        if5.refill_req_i = 1'b1;
        if5.refill_adr_i = 32'h0000_0040;
        tick();
        if5.refill_req_i = 1'b0;
        if5.ibus_ack_i   = 1'b1;
        tick();
        tick();
        if5.ibus_err_i = 1'b1;
        #1;
        check("t3_err_adr", if5.ibus_adr_o,       32'h0000_0048);
        check("t3_err_we",  {31'b0, if5.ic_we_o}, 32'd0);
        check("t3_err_o0",  {31'b0, if5.err_o},   32'd0);
        tick();
        if5.ibus_ack_i = 1'b0;
        if5.ibus_err_i = 1'b0;
        #1;
        check("t3_err_o1",  {31'b0, if5.err_o},      32'd1);
        check("t3_req_low", {31'b0, if5.ibus_req_o}, 32'd0);
        check("t3_busy1",   {31'b0, if5.busy_o},     32'd1);
        tick();
        #1;
        check("t3_err_o2", {31'b0, if5.err_o},  32'd0);
        check("t3_busy2",  {31'b0, if5.busy_o}, 32'd0);
        tick();

        // BW=5, reset on the second beat while ack stays high
        if5.refill_req_i = 1'b1;
        if5.refill_adr_i = 32'h0000_0080;
        tick();
        if5.refill_req_i = 1'b0;
        if5.ibus_ack_i   = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t4_we",    {31'b0, if5.ic_we_o},      32'd0);
        check("t4_req",   {31'b0, if5.ibus_req_o},   32'd0);
        check("t4_burst", {31'b0, if5.ibus_burst_o}, 32'd0);
        check("t4_busy",  {31'b0, if5.busy_o},       32'd0);
        check("t4_err",   {31'b0, if5.err_o},        32'd0);
        check("t4_adr",   if5.ibus_adr_o,            32'd0);
        check("t4_wradr", if5.ic_wradr_o,            32'd0);
        tick();
        #1;
        check("t4_we_late", {31'b0, if5.ic_we_o}, 32'd0);
        if5.ibus_ack_i = 1'b0;
        tick();

        // BW=4, request held high across two refills
        if4.refill_req_i = 1'b1;
        if4.refill_adr_i = 32'h0000_0100;
        tick();
        if4.refill_adr_i = 32'h0000_0200;
        if4.ibus_ack_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_a_adr", if4.ibus_adr_o,       32'h0000_0100 + 4 * i);
            check("t5_a_we",  {31'b0, if4.ic_we_o}, 32'd1);
            tick();
        end
        if4.ibus_ack_i = 1'b0;
        #1;
        check("t5_gap_req",  {31'b0, if4.ibus_req_o}, 32'd0);
        check("t5_gap_busy", {31'b0, if4.busy_o},     32'd0);
        tick();
        #1;
        check("t5_b_req",   {31'b0, if4.ibus_req_o}, 32'd1);
        check("t5_b_start", if4.ibus_adr_o,          32'h0000_0200);
        if4.refill_req_i = 1'b0;
        if4.ibus_ack_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_b_adr", if4.ibus_adr_o,       32'h0000_0200 + 4 * i);
            check("t5_b_we",  {31'b0, if4.ic_we_o}, 32'd1);
            tick();
        end
        if4.ibus_ack_i = 1'b0;
        #1;
        check("t5_end_busy", {31'b0, if4.busy_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
